// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding and direction constants for the intersection controller.
package traffic_pkg;
    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5,
        FLASH     = 3'd6
    } state_e;
    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that flags expiry when it reads zero and holds there.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign expired_o = cnt_q == '0;
    assign cnt_d = load_i ? load_val_i : (expired_o ? cnt_q : cnt_q - CNT_W'(1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= RST_VAL;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/traffic_intersection.sv
// traffic_intersection: two-road light controller with all-red clearance,
// latched pedestrian walk phase and flashing-yellow maintenance mode.
module traffic_intersection
    import traffic_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int PED_TICKS    = 10,
    parameter int FLASH_TICKS  = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic ped_req,
    input  logic flash_mode,
    output logic ns_r,
    output logic ns_y,
    output logic ns_g,
    output logic ew_r,
    output logic ew_y,
    output logic ew_g,
    output logic ped_walk,
    output logic ped_pending
);
    localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] AR_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] PD_LD = CNT_W'(PED_TICKS - 1);
    localparam logic [CNT_W-1:0] FL_LD = CNT_W'(FLASH_TICKS - 1);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic             pend_q, pend_d;
    logic             tog_q, tog_d;
    logic [6:0]       lamp_q, lamp_d;
    logic             expired, load;
    logic [CNT_W-1:0] load_val;

    phase_timer #(.CNT_W(CNT_W), .RST_VAL(AR_LD)) u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .expired_o  (expired)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        if (flash_mode) state_d = FLASH;
        else if (state_q == FLASH) begin
            state_d = ALL_RED;
            dir_d   = DIR_NS;
        end else if (expired) begin
            case (state_q)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: begin state_d = ALL_RED; dir_d = DIR_EW; end
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: begin state_d = ALL_RED; dir_d = DIR_NS; end
                ALL_RED:   state_d = pend_q ? PED_WALK : (dir_q == DIR_NS ? NS_GREEN : EW_GREEN);
                PED_WALK:  state_d = dir_q == DIR_NS ? NS_GREEN : EW_GREEN;
                default:   state_d = ALL_RED;
            endcase
        end
        // FLASH reloads on every expiry to time the next half-period
        load     = (state_d != state_q) || expired;
        load_val = state_d == FLASH ? FL_LD :
                   state_d == PED_WALK ? PD_LD :
                   state_d inside {NS_GREEN, EW_GREEN} ? G_LD :
                   state_d inside {NS_YELLOW, EW_YELLOW} ? Y_LD : AR_LD;
        // a request on the walk-entry cycle survives the clear
        pend_d = state_d == FLASH ? 1'b0 :
                 (state_q != FLASH && ped_req) ? 1'b1 :
                 (state_d == PED_WALK && state_q != PED_WALK) ? 1'b0 : pend_q;
        tog_d  = state_d != FLASH ? 1'b0 : state_q != FLASH ? 1'b1 : tog_q ^ expired;
        lamp_d = {state_d inside {ALL_RED, PED_WALK, EW_GREEN, EW_YELLOW},
                  state_d == NS_YELLOW || (state_d == FLASH && tog_d),
                  state_d == NS_GREEN,
                  state_d inside {ALL_RED, PED_WALK, NS_GREEN, NS_YELLOW},
                  state_d == EW_YELLOW || (state_d == FLASH && tog_d),
                  state_d == EW_GREEN,
                  state_d == PED_WALK};
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= ALL_RED;
            dir_q   <= DIR_NS;
            pend_q  <= 1'b0;
            tog_q   <= 1'b0;
            lamp_q  <= 7'b1001000;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            tog_q   <= tog_d;
            lamp_q  <= lamp_d;
        end

    assign {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk} = lamp_q;
    assign ped_pending = pend_q;
endmodule

// File: tb/tb_traffic_intersection.sv
// tb_traffic_intersection: vector table on the default-parameter controller plus a
// randomized run of a short-timing instance against a phase/remaining-cycles model.
module tb_traffic_intersection;
    localparam logic [5:0] AR = 6'b100100, NSG = 6'b001100, NSY = 6'b010100;
    localparam logic [5:0] EWG = 6'b100001, EWY = 6'b100010, FON = 6'b010010, FOFF = 6'b000000;
    localparam int SG = 3, SY = 1, SA = 1, SP = 2, SF = 5;
    localparam int M_AR = 0, M_NSG = 1, M_NSY = 2, M_EWG = 3, M_EWY = 4, M_WALK = 5, M_FL = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, ped_req = 1'b0, flash_mode = 1'b0;
    logic ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk, ped_pending;
    logic reset2 = 1'b0, ped2 = 1'b0, flash2 = 1'b0;
    logic s_ns_r, s_ns_y, s_ns_g, s_ew_r, s_ew_y, s_ew_g, s_walk, s_pend;
    logic [7:0] obs, obs2;

    traffic_intersection dut (
        .clk(clk), .reset(reset), .ped_req(ped_req), .flash_mode(flash_mode),
        .ns_r(ns_r), .ns_y(ns_y), .ns_g(ns_g), .ew_r(ew_r), .ew_y(ew_y), .ew_g(ew_g),
        .ped_walk(ped_walk), .ped_pending(ped_pending)
    );

    traffic_intersection #(.GREEN_TICKS(SG), .YELLOW_TICKS(SY), .ALLRED_TICKS(SA), .PED_TICKS(SP)) dut2 (
        .clk(clk), .reset(reset2), .ped_req(ped2), .flash_mode(flash2),
        .ns_r(s_ns_r), .ns_y(s_ns_y), .ns_g(s_ns_g), .ew_r(s_ew_r), .ew_y(s_ew_y), .ew_g(s_ew_g),
        .ped_walk(s_walk), .ped_pending(s_pend)
    );

    assign obs  = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk, ped_pending};
    assign obs2 = {s_ns_r, s_ns_y, s_ns_g, s_ew_r, s_ew_y, s_ew_g, s_walk, s_pend};

    int vectors = 0, miscompares = 0, cyc = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    typedef struct {
        bit         first;
        int         cyc;
        bit         ped;
        bit         fl;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit first, input int c, input bit p, input bit f,
                                input logic [5:0] l, input bit w, input bit pend);
        vec_t v;
        v.first = first; v.cyc = c; v.ped = p; v.fl = f; v.exp = {l, w, pend};
        tbl.push_back(v);
    endfunction

    task automatic start();
        reset = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1; cyc = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    int  m_ph, m_left;
    bit  m_dir, m_pend, m_tog;

    function automatic void m_reset();
        m_ph = M_AR; m_left = SA; m_dir = 1'b0; m_pend = 1'b0; m_tog = 1'b0;
    endfunction

    function automatic logic [7:0] m_out();
        case (m_ph)
            M_NSG:   return {NSG, 1'b0, m_pend};
            M_NSY:   return {NSY, 1'b0, m_pend};
            M_EWG:   return {EWG, 1'b0, m_pend};
            M_EWY:   return {EWY, 1'b0, m_pend};
            M_WALK:  return {AR, 1'b1, m_pend};
            M_FL:    return {1'b0, m_tog, 2'b00, m_tog, 1'b0, 1'b0, m_pend};
            default: return {AR, 1'b0, m_pend};
        endcase
    endfunction

    // advance the model across one clock edge with the inputs sampled at it
    function automatic void m_step(input bit p, input bit f);
        bit walk_entry;
        walk_entry = 1'b0;
        if (f) begin
            if (m_ph != M_FL) begin
                m_ph = M_FL; m_left = SF; m_tog = 1'b1;
            end else begin
                m_left--;
                if (m_left == 0) begin m_tog = !m_tog; m_left = SF; end
            end
            m_pend = 1'b0;
        end else if (m_ph == M_FL) begin
            m_ph = M_AR; m_left = SA; m_dir = 1'b0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                case (m_ph)
                    M_NSG: begin m_ph = M_NSY; m_left = SY; end
                    M_NSY: begin m_ph = M_AR; m_left = SA; m_dir = 1'b1; end
                    M_EWG: begin m_ph = M_EWY; m_left = SY; end
                    M_EWY: begin m_ph = M_AR; m_left = SA; m_dir = 1'b0; end
                    M_AR:
                        if (m_pend) begin m_ph = M_WALK; m_left = SP; walk_entry = 1'b1; end
                        else begin m_ph = m_dir ? M_EWG : M_NSG; m_left = SG; end
                    default: begin m_ph = m_dir ? M_EWG : M_NSG; m_left = SG; end
                endcase
            end
            m_pend = p | (m_pend & !walk_entry);
        end
    endfunction

    initial begin
        bit ok;
        // plain vehicle cycle
        add(1, 0, 0, 0, AR, 0, 0);   add(0, 1, 0, 0, AR, 0, 0);   add(0, 2, 0, 0, NSG, 0, 0);
        add(0, 21, 0, 0, NSG, 0, 0); add(0, 22, 0, 0, NSY, 0, 0); add(0, 25, 0, 0, NSY, 0, 0);
        add(0, 26, 0, 0, AR, 0, 0);  add(0, 27, 0, 0, AR, 0, 0);  add(0, 28, 0, 0, EWG, 0, 0);
        add(0, 47, 0, 0, EWG, 0, 0); add(0, 48, 0, 0, EWY, 0, 0); add(0, 51, 0, 0, EWY, 0, 0);
        add(0, 52, 0, 0, AR, 0, 0);  add(0, 53, 0, 0, AR, 0, 0);  add(0, 54, 0, 0, NSG, 0, 0);
        // pedestrian pulse at cycle 10
        add(1, 0, 0, 0, AR, 0, 0);   add(0, 10, 1, 0, NSG, 0, 0); add(0, 11, 0, 0, NSG, 0, 1);
        add(0, 21, 0, 0, NSG, 0, 1); add(0, 22, 0, 0, NSY, 0, 1); add(0, 26, 0, 0, AR, 0, 1);
        add(0, 27, 0, 0, AR, 0, 1);  add(0, 28, 0, 0, AR, 1, 0);  add(0, 37, 0, 0, AR, 1, 0);
        add(0, 38, 0, 0, EWG, 0, 0); add(0, 57, 0, 0, EWG, 0, 0); add(0, 58, 0, 0, EWY, 0, 0);
        // flash window 15..39, with a ped press that must be ignored
        add(1, 0, 0, 0, AR, 0, 0);   add(0, 15, 0, 1, NSG, 0, 0); add(0, 16, 0, 1, FON, 0, 0);
        add(0, 18, 1, 1, FON, 0, 0); add(0, 19, 0, 1, FON, 0, 0); add(0, 20, 0, 1, FON, 0, 0);
        add(0, 21, 0, 1, FOFF, 0, 0); add(0, 25, 0, 1, FOFF, 0, 0); add(0, 26, 0, 1, FON, 0, 0);
        add(0, 31, 0, 1, FOFF, 0, 0); add(0, 36, 0, 1, FON, 0, 0); add(0, 40, 0, 0, FON, 0, 0);
        add(0, 41, 0, 0, AR, 0, 0);  add(0, 42, 0, 0, AR, 0, 0);  add(0, 43, 0, 0, NSG, 0, 0);
        add(0, 62, 0, 0, NSG, 0, 0); add(0, 63, 0, 0, NSY, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].first) start();
            else while (cyc < tbl[i].cyc) step();
            ped_req = tbl[i].ped;
            flash_mode = tbl[i].fl;
            chk($sformatf("tbl[%0d] cyc %0d", i, cyc), obs, tbl[i].exp);
        end

        // asynchronous reset in the middle of EW yellow, then a clean restart
        start();
        while (cyc < 49) step();
        @(posedge clk); #2 reset = 1'b0;
        #1 chk("async reset", obs, {AR, 2'b00});
        repeat (3) @(negedge clk);
        chk("reset held", obs, {AR, 2'b00});
        reset = 1'b1; cyc = 0;
        chk("restart c0", obs, {AR, 2'b00});
        while (cyc < 2) step();
        chk("restart c2", obs, {NSG, 2'b00});
        while (cyc < 22) step();
        chk("restart c22", obs, {NSY, 2'b00});
        while (cyc < 28) step();
        chk("restart c28", obs, {EWG, 2'b00});

        // short-timing instance: ten-cycle vehicle loop
        reset2 = 1'b0; @(negedge clk); reset2 = 1'b1; cyc = 0;
        chk("short c0", obs2, {AR, 2'b00});
        step();
        chk("short c1", obs2, {NSG, 2'b00});
        while (cyc < 11) step();
        chk("short c11", obs2, {NSG, 2'b00});

        // randomized run against the model, with the safety check every cycle
        reset2 = 1'b0; @(negedge clk); reset2 = 1'b1;
        m_reset();
        for (int i = 0; i < 1000; i++) begin
            chk($sformatf("rand %0d", i), obs2, m_out());
            if (m_ph != M_FL) begin
                ok = (s_ns_r | s_ew_r) && $onehot({s_ns_r, s_ns_y, s_ns_g}) && $onehot({s_ew_r, s_ew_y, s_ew_g});
                chk($sformatf("safety %0d", i), {7'b0, ok}, 8'd1);
            end
            ped2 = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) flash2 = !flash2;
            m_step(ped2, flash2);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/traffic_intersection.md
Name: traffic_intersection

Overview:
- Parametrised two-road (north-south / east-west) traffic-light controller; successor to the single-signal-head `traffic` block.
- Adds the following over `traffic`:
  - configurable phase durations
  - an all-red clearance interval
  - a latched pedestrian-walk request
  - a flashing-yellow maintenance mode
- Moore FSM plus one down-counter, clocked by the single system clock.
- Drives two signal heads and one walk lamp.

Parameters:
- CNT_W, 8, width of the phase down-counter. Every *_TICKS value must be at most 2^CNT_W.
- GREEN_TICKS, 20, cycles each direction holds green.
- YELLOW_TICKS, 4, cycles of yellow after each green.
- ALLRED_TICKS, 2, cycles of all-red clearance after each yellow.
- PED_TICKS, 10, cycles of pedestrian walk, with all vehicle lamps red.
- FLASH_TICKS, 5, half-period of the flashing yellow in FLASH mode.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low. 0 resets the block; 1 runs it.
- ped_req  input  1  pedestrian button, level or pulse. Sampled every cycle.
- flash_mode  input  1  1 forces flashing-yellow maintenance mode.
- ns_r, ns_y, ns_g  output  1 each  north-south lamps.
- ew_r, ew_y, ew_g  output  1 each  east-west lamps.
- ped_walk  output  1  walk lamp.
- ped_pending  output  1  a pedestrian request is latched and not yet served.

Behaviour:
- States: ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, PED_WALK, FLASH.
- State timing:
  - A state of duration N lasts exactly N cycles.
  - On entry the counter loads N-1 and decrements once per cycle.
  - The transition happens on the cycle after the counter reads 0.
- Reset (reset==0):
  - State = ALL_RED, counter = ALLRED_TICKS-1, next_dir = NS.
  - ped_pending = 0, flash toggle = 0.
  - Outputs: ns_r = ew_r = 1, all other lamps 0, ped_walk = 0.
  - Reset applies asynchronously, including mid-phase. Release is sampled on the next rising clock edge.
- Transitions when the counter expires:
  - NS_GREEN -> NS_YELLOW -> ALL_RED, with next_dir set to EW.
  - EW_GREEN -> EW_YELLOW -> ALL_RED, with next_dir set to NS.
  - ALL_RED -> PED_WALK if ped_pending, otherwise the green of next_dir.
  - PED_WALK -> the green of next_dir; ped_pending clears on entry to PED_WALK.
- Pedestrian latching:
  - ped_pending is set by ped_req==1 in any non-FLASH state.
  - Set wins over clear in the same cycle, so a request arriving on the PED_WALK entry cycle stays pending.
- Lamp outputs:
  - Registered Moore decode of the state.
  - The direction not named in the state shows red.
  - ALL_RED and PED_WALK: both red. ped_walk = 1 only in PED_WALK.
- FLASH mode:
  - flash_mode==1 in any state enters FLASH on the next edge, overriding any remaining count.
  - On entry: ped_pending cleared, toggle = 1, counter = FLASH_TICKS-1.
  - In FLASH: ns_y = ew_y = toggle; every other lamp 0; ped_req ignored. Toggle inverts each time the counter expires.
  - flash_mode==0 while in FLASH leads to ALL_RED with next_dir = NS and a full ALLRED_TICKS count.
- Safety invariant: outside FLASH, at least one direction shows red in every cycle. Exactly one lamp per head is lit.
- Full vehicle cycle with no pedestrian request: 2*(GREEN_TICKS+YELLOW_TICKS+ALLRED_TICKS) cycles, 52 at defaults.
- Counter width: computed as CNT_W bits. No wrap is possible, because the transition fires at 0 before any decrement below 0.

Decomposition:
- Shared package `traffic_pkg` holds:
  - the state enum: ALL_RED=0, NS_GREEN=1, NS_YELLOW=2, EW_GREEN=3, EW_YELLOW=4, PED_WALK=5, FLASH=6, in 3 bits;
  - the direction constants DIR_NS=0, DIR_EW=1.
- One natural sub-module, `phase_timer`:
  - loadable CNT_W-bit down-counter;
  - inputs: load, load_val;
  - output: expired (count==0).
- The FSM, pedestrian latch and lamp decode stay in the top module.

Test Plan:
- Reset and release at cycle 0 with defaults:
  - cycles 0-1 all red;
  - NS green 2-21;
  - NS yellow 22-25;
  - all red 26-27;
  - EW green 28-47;
  - NS green again at cycle 54.
- ped_req pulsed for 1 cycle at cycle 10 (during NS green):
  - ped_pending rises at cycle 11;
  - NS yellow 22-25, then all red 26-27;
  - ped_walk = 1 for cycles 28-37 with all vehicle lamps red;
  - EW green from cycle 38; ped_pending = 0 from cycle 28.
- flash_mode=1 at cycle 15:
  - from cycle 16, ns_y = ew_y = 1 for 5 cycles, then 0 for 5 cycles, repeating;
  - all other lamps 0.
  - Deassert at cycle 40: 2 cycles of all red, then NS green.
- Reset asserted mid EW_YELLOW for 3 cycles:
  - outputs show all red immediately (asynchronously);
  - after release the sequence restarts exactly as in the first scenario.
- Parameter override GREEN_TICKS=3, YELLOW_TICKS=1, ALLRED_TICKS=1, PED_TICKS=2:
  - vehicle cycle is 10 cycles;
  - the safety invariant holds (assertion) over 1000 random ped_req cycles.
